// File: rtl/ram_param_sweep_pkg.sv
// Shared definitions for the swept RAM: request encodings, FSM state codes,
// the address-width helper and the request-decode bundle.
package ram_param_sweep_pkg;

  localparam logic RW_READ  = 1'b0;
  localparam logic RW_WRITE = 1'b1;

  localparam logic [0:0] S_SWEEP = 1'b0;
  localparam logic [0:0] S_IDLE  = 1'b1;

  typedef struct packed {
    logic accept;
    logic reject;
    logic is_write;
  } req_dec_t;

  function automatic int clog2_int(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((32'sd1 <<< i) < n) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/ram_param_sweep_word.sv
// One storage word of the swept RAM. Contents are deliberately not reset;
// the clear sweep in the top level zeroes them.
module ram_param_sweep_word #(
  parameter int WIDTH = 8
) (
  input  logic             clock,
  input  logic             i_we,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_q;

  // Capture write data when this word is selected.
  always_ff @(posedge clock) begin
    if (i_we) r_q <= i_d;
  end

  assign o_q = r_q;

endmodule

// File: rtl/ram_param_sweep.sv
// Single-port RAM with registered read, valid/error strobes and a clear sweep
// that zeroes one word per cycle after reset or on a wipe request.
module ram_param_sweep
  import ram_param_sweep_pkg::*;
#(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 4,
  localparam int AW    = clog2_int(DEPTH)
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             enable,
  input  logic             rw,
  input  logic [AW-1:0]    address,
  input  logic [WIDTH-1:0] data_in,
  input  logic             wipe,
  output logic [WIDTH-1:0] data_out,
  output logic             valid,
  output logic             busy,
  output logic             error
);

  localparam logic [AW-1:0] LAST    = AW'(DEPTH - 1);
  localparam logic [AW:0]   DEPTH_W = (AW + 1)'(DEPTH);

  logic [0:0]       r_state;
  logic [AW-1:0]    r_ptr;
  logic [WIDTH-1:0] r_data_out;
  logic             r_valid;
  logic             r_error;

  logic             w_sweep;
  logic             w_in_range;
  req_dec_t         w_req;
  logic [DEPTH-1:0] w_we;
  logic [WIDTH-1:0] w_wdata;
  logic [WIDTH-1:0] w_word [DEPTH];
  logic [WIDTH-1:0] w_rd_data;

  assign w_sweep    = (r_state == S_SWEEP);
  assign w_in_range = ({1'b0, address} < DEPTH_W);

  // Classify the incoming request; wipe wins over a same-cycle request.
  always_comb begin
    w_req = '0;
    if (enable) begin
      if (w_sweep || wipe || !w_in_range) begin
        w_req.reject = 1'b1;
      end else begin
        w_req.accept   = 1'b1;
        w_req.is_write = (rw == RW_WRITE);
      end
    end else begin
      w_req = '0;
    end
  end

  assign w_wdata = w_sweep ? '0 : data_in;

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_word
    assign w_we[gi] = w_sweep ? (r_ptr == AW'(gi))
                              : (w_req.accept && w_req.is_write && (address == AW'(gi)));
    ram_param_sweep_word #(.WIDTH(WIDTH)) u_word (
      .clock (clock),
      .i_we  (w_we[gi]),
      .i_d   (w_wdata),
      .o_q   (w_word[gi])
    );
  end

  // DEPTH:1 read mux as an AND-OR tree of the one-hot address match.
  always_comb begin
    w_rd_data = '0;
    for (int i = 0; i < DEPTH; i++) begin
      w_rd_data = w_rd_data | ({WIDTH{address == AW'(i)}} & w_word[i]);
    end
  end

  // Sweep FSM and pointer; the pointer stops at LAST so it never wraps.
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      r_state <= S_SWEEP;
      r_ptr   <= '0;
    end else begin
      case (r_state)
        S_SWEEP: begin
          if (r_ptr == LAST) begin
            r_state <= S_IDLE;
            r_ptr   <= '0;
          end else begin
            r_ptr <= r_ptr + AW'(1);
          end
        end
        S_IDLE: begin
          if (wipe) begin
            r_state <= S_SWEEP;
            r_ptr   <= '0;
          end
        end
        default: begin
          r_state <= S_SWEEP;
          r_ptr   <= '0;
        end
      endcase
    end
  end

  // Read data register and the single-cycle valid/error strobes.
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      r_data_out <= '0;
      r_valid    <= 1'b0;
      r_error    <= 1'b0;
    end else begin
      r_valid <= w_req.accept && !w_req.is_write;
      r_error <= w_req.reject;
      if (w_req.accept && !w_req.is_write) r_data_out <= w_rd_data;
    end
  end

  assign data_out = r_data_out;
  assign valid    = r_valid;
  assign error    = r_error;
  assign busy     = w_sweep;

endmodule

// File: tb/tb_ram_param_sweep.sv
// Scoreboard bench: stimulus pushes expected responses tagged with the cycle
// they must appear in; a negedge monitor pops and compares them.
module tb_ram_param_sweep;

  typedef struct {
    logic       v;
    logic       e;
    logic [7:0] d;
    int         cyc;
  } exp_t;

  logic       clk;
  logic       clear4, en4, rw4, wipe4, valid4, busy4, err4;
  logic [1:0] addr4;
  logic [7:0] din4, dout4;
  logic       clear3, en3, rw3, wipe3, valid3, busy3, err3;
  logic [1:0] addr3;
  logic [7:0] din3, dout3;

  exp_t q [2][$];
  int   cyc    = 0;
  int   checks = 0;
  int   errors = 0;
  logic [7:0] last4, last3;

  ram_param_sweep #(.WIDTH(8), .DEPTH(4)) dut4 (
    .clock(clk), .clear(clear4), .enable(en4), .rw(rw4), .address(addr4),
    .data_in(din4), .wipe(wipe4), .data_out(dout4), .valid(valid4),
    .busy(busy4), .error(err4)
  );

  ram_param_sweep #(.WIDTH(8), .DEPTH(3)) dut3 (
    .clock(clk), .clear(clear3), .enable(en3), .rw(rw3), .address(addr3),
    .data_in(din3), .wipe(wipe3), .data_out(dout3), .valid(valid3),
    .busy(busy3), .error(err3)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic monitor(input int p, input logic v, input logic e, input logic [7:0] d);
    exp_t x;
    while (q[p].size() > 0 && q[p][0].cyc < cyc) begin
      x = q[p].pop_front();
      checks++;
      errors++;
      $display("FAIL mon%0d_missing: no response at cycle %0d, expected v=%b e=%b d=%h",
               p, x.cyc, x.v, x.e, x.d);
    end
    if (q[p].size() > 0 && q[p][0].cyc == cyc) begin
      x = q[p].pop_front();
      checks++;
      if (v !== x.v || e !== x.e || d !== x.d) begin
        errors++;
        $display("FAIL mon%0d_resp: cycle %0d got v=%b e=%b d=%h expected v=%b e=%b d=%h",
                 p, cyc, v, e, d, x.v, x.e, x.d);
      end
    end else if (v !== 1'b0 || e !== 1'b0) begin
      checks++;
      errors++;
      $display("FAIL mon%0d_unexpected: cycle %0d got v=%b e=%b expected v=0 e=0", p, cyc, v, e);
    end
  endtask

  always @(negedge clk) begin
    monitor(0, valid4, err4, dout4);
    monitor(1, valid3, err3, dout3);
  end

  task automatic push(input int p, input logic v, input logic e, input logic [7:0] d);
    exp_t x;
    x.v = v; x.e = e; x.d = d; x.cyc = cyc + 1;
    q[p].push_back(x);
  endtask

  // All ops are issued at 1 time unit after a rising edge and last one cycle.
  task automatic op4(input logic en, input logic w, input logic [1:0] a,
                     input logic [7:0] dd, input logic wp);
    en4 = en; rw4 = w; addr4 = a; din4 = dd; wipe4 = wp;
    @(posedge clk); #1;
    en4 = 1'b0; wipe4 = 1'b0;
  endtask

  task automatic op3(input logic en, input logic w, input logic [1:0] a, input logic [7:0] dd);
    en3 = en; rw3 = w; addr3 = a; din3 = dd;
    @(posedge clk); #1;
    en3 = 1'b0;
  endtask

  task automatic rd4(input logic [1:0] a, input logic [7:0] exp);
    push(0, 1'b1, 1'b0, exp);
    last4 = exp;
    op4(1'b1, 1'b0, a, 8'h00, 1'b0);
  endtask

  task automatic wr4(input logic [1:0] a, input logic [7:0] d);
    op4(1'b1, 1'b1, a, d, 1'b0);
  endtask

  task automatic busy_window4(input int n);
    for (int k = 0; k < n; k++) begin
      chk("busy_on", {31'd0, busy4}, 32'd1);
      op4(1'b0, 1'b0, 2'd0, 8'h00, 1'b0);
    end
    chk("busy_off", {31'd0, busy4}, 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    clk = 1'b0;
    clear4 = 1'b0; en4 = 1'b0; rw4 = 1'b0; addr4 = 2'd0; din4 = 8'h00; wipe4 = 1'b0;
    clear3 = 1'b0; en3 = 1'b0; rw3 = 1'b0; addr3 = 2'd0; din3 = 8'h00; wipe3 = 1'b0;
    last4 = 8'h00; last3 = 8'h00;

    // Reset state, then sweep length after release.
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy",  {31'd0, busy4},  32'd1);
    chk("rst_valid", {31'd0, valid4}, 32'd0);
    chk("rst_error", {31'd0, err4},   32'd0);
    chk("rst_dout",  {24'd0, dout4},  32'd0);
    clear4 = 1'b1;
    clear3 = 1'b1;
    busy_window4(4);
    for (int i = 0; i < 4; i++) rd4(2'(i), 8'h00);

    // Write/read, back-to-back reads, read right after write.
    wr4(2'd1, 8'hA5);
    wr4(2'd2, 8'h3C);
    rd4(2'd1, 8'hA5);
    rd4(2'd2, 8'h3C);
    wr4(2'd3, 8'h7E);
    rd4(2'd3, 8'h7E);

    // Wipe beats a same-cycle read; a write during the sweep is rejected.
    for (int i = 0; i < 4; i++) wr4(2'(i), 8'hFF);
    push(0, 1'b0, 1'b1, last4);
    op4(1'b1, 1'b0, 2'd0, 8'h00, 1'b1);
    for (int k = 0; k < 4; k++) begin
      chk("wipe_busy_on", {31'd0, busy4}, 32'd1);
      if (k == 2) begin
        push(0, 1'b0, 1'b1, last4);
        op4(1'b1, 1'b1, 2'd0, 8'h11, 1'b0);
      end else begin
        op4(1'b0, 1'b0, 2'd0, 8'h00, 1'b0);
      end
    end
    chk("wipe_busy_off", {31'd0, busy4}, 32'd0);
    for (int i = 0; i < 4; i++) rd4(2'(i), 8'h00);

    // Out of range on the 3-deep instance: data_out holds, valid stays low.
    op3(1'b1, 1'b1, 2'd2, 8'h5A);
    push(1, 1'b1, 1'b0, 8'h5A);
    op3(1'b1, 1'b0, 2'd2, 8'h00);
    push(1, 1'b0, 1'b1, 8'h5A);
    op3(1'b1, 1'b0, 2'd3, 8'h00);
    push(1, 1'b0, 1'b1, 8'h5A);
    op3(1'b1, 1'b1, 2'd3, 8'hC3);
    push(1, 1'b1, 1'b0, 8'h00);
    op3(1'b1, 1'b0, 2'd0, 8'h00);

    // Reset two cycles into a wipe sweep; the sweep restarts from word 0.
    for (int i = 0; i < 4; i++) wr4(2'(i), 8'h55);
    rd4(2'd3, 8'h55);
    op4(1'b0, 1'b0, 2'd0, 8'h00, 1'b1);
    op4(1'b0, 1'b0, 2'd0, 8'h00, 1'b0);
    op4(1'b0, 1'b0, 2'd0, 8'h00, 1'b0);
    clear4 = 1'b0;
    #1;
    chk("mid_rst_dout", {24'd0, dout4}, 32'd0);
    chk("mid_rst_busy", {31'd0, busy4}, 32'd1);
    repeat (2) @(posedge clk);
    #1;
    clear4 = 1'b1;
    busy_window4(4);
    for (int i = 0; i < 4; i++) rd4(2'(i), 8'h00);

    repeat (3) @(posedge clk);
    #1;
    chk("queue_drain", 32'(q[0].size() + q[1].size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
